// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the streaming convolution engine.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam int PIX_W = 8;

    function automatic int out_dim(input int n, input int k, input int s);
        return (n - k) / s + 1;
    endfunction

    // Products are 2*w bits; summing k*k of them needs clog2(k*k) carry bits.
    function automatic int acc_width(input int w, input int k);
        return 2 * w + $clog2(k * k);
    endfunction

    typedef logic [PIX_W-1:0]                 pixel_t;
    typedef logic [acc_width(PIX_W, 3)-1:0]   acc_t;

endpackage

// File: rtl/conv_line_buffer.sv
// Row FIFOs plus window history; `window` is the window as it will look once
// the pixel on `pix` is shifted in, so callers can compute on it the same cycle.
module conv_line_buffer #(
    parameter int IMG_W     = 7,
    parameter int KSIZE     = 3,
    parameter int WIDTH_BIT = 8
) (
    input  logic                                       clock,
    input  logic                                       shift,
    input  logic [WIDTH_BIT-1:0]                       pix,
    output logic [KSIZE-1:0][KSIZE-1:0][WIDTH_BIT-1:0] window
);

    generate
        if (KSIZE > 1) begin : g_multi
            // row_in[KSIZE-1] is the current row; lower indices are older rows.
            logic [KSIZE-1:0][WIDTH_BIT-1:0]            row_in;
            logic [IMG_W-1:0][WIDTH_BIT-1:0]            fifo [KSIZE-1];
            logic [KSIZE-1:0][KSIZE-2:0][WIDTH_BIT-1:0] hist;

            assign row_in[KSIZE-1] = pix;

            for (genvar i = 0; i < KSIZE - 1; i++) begin : g_row
                always_ff @(posedge clock) begin
                    if (shift) begin
                        fifo[i] <= {fifo[i][IMG_W-2:0], row_in[KSIZE-1-i]};
                    end
                end
                assign row_in[KSIZE-2-i] = fifo[i][IMG_W-1];
            end

            always_comb begin
                for (int r = 0; r < KSIZE; r++) begin
                    for (int c = 0; c < KSIZE - 1; c++) begin
                        window[r][c] = hist[r][c];
                    end
                    window[r][KSIZE-1] = row_in[r];
                end
            end

            always_ff @(posedge clock) begin
                if (shift) begin
                    for (int r = 0; r < KSIZE; r++) begin
                        for (int c = 0; c < KSIZE - 1; c++) begin
                            hist[r][c] <= window[r][c+1];
                        end
                    end
                end
            end
        end else begin : g_single
            assign window[0][0] = pix;
        end
    endgenerate

endmodule

// File: rtl/conv2_stream.sv
// Streaming KSIZE x KSIZE convolution over one raster-order image per start,
// emitting valid-region results with stride, shift and saturate/truncate.
module conv2_stream
    import conv_pkg::*;
#(
    parameter int IMG_W     = 7,
    parameter int IMG_H     = 7,
    parameter int KSIZE     = 3,
    parameter int WIDTH_BIT = 8,
    parameter int STRIDE    = 1,
    parameter int SHIFT     = 0,
    parameter int SATURATE  = 1
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       start,
    input  logic [KSIZE-1:0][KSIZE-1:0][WIDTH_BIT-1:0] kernel_in,
    input  logic                                       pix_valid,
    output logic                                       pix_ready,
    input  logic [WIDTH_BIT-1:0]                       pix_data,
    output logic                                       out_valid,
    input  logic                                       out_ready,
    output logic [WIDTH_BIT-1:0]                       out_data,
    output logic                                       out_last,
    output logic                                       busy,
    output logic                                       done,
    output state_t                                     fsm_state
);

    localparam int OUT_W    = out_dim(IMG_W, KSIZE, STRIDE);
    localparam int OUT_H    = out_dim(IMG_H, KSIZE, STRIDE);
    localparam int ACC_W    = acc_width(WIDTH_BIT, KSIZE);
    localparam int PROD_W   = 2 * WIDTH_BIT;
    localparam int LAST_ROW = (OUT_H - 1) * STRIDE + KSIZE - 1;
    localparam int LAST_COL = (OUT_W - 1) * STRIDE + KSIZE - 1;
    localparam int CW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW       = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_t                                     state;
    logic [CW-1:0]                              col;
    logic [RW-1:0]                              row;
    logic [KSIZE-1:0][KSIZE-1:0][WIDTH_BIT-1:0] kern;
    logic [KSIZE-1:0][KSIZE-1:0][WIDTH_BIT-1:0] window;

    logic                 xfer;
    logic                 row_ok;
    logic                 col_ok;
    logic                 win_done;
    logic                 last_win;
    logic                 last_pix;
    logic [PROD_W-1:0]    prod;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     res;
    logic [WIDTH_BIT-1:0] narrow;

    assign pix_ready = (state == RUN) && (!out_valid || out_ready);
    assign xfer      = pix_valid && pix_ready;
    assign fsm_state = state;

    conv_line_buffer #(
        .IMG_W    (IMG_W),
        .KSIZE    (KSIZE),
        .WIDTH_BIT(WIDTH_BIT)
    ) u_line_buffer (
        .clock (clock),
        .shift (xfer),
        .pix   (pix_data),
        .window(window)
    );

    always_comb begin
        row_ok   = (int'(row) >= KSIZE - 1) && (((int'(row) - (KSIZE - 1)) % STRIDE) == 0);
        col_ok   = (int'(col) >= KSIZE - 1) && (((int'(col) - (KSIZE - 1)) % STRIDE) == 0);
        win_done = xfer && row_ok && col_ok;
        last_win = (int'(row) == LAST_ROW) && (int'(col) == LAST_COL);
        last_pix = (int'(row) == IMG_H - 1) && (int'(col) == IMG_W - 1);
    end

    // MAC over the window that includes the pixel being accepted this cycle.
    always_comb begin
        prod = '0;
        acc  = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                prod = PROD_W'(window[r][c]) * PROD_W'(kern[r][c]);
                acc  = acc + ACC_W'(prod);
            end
        end
        res = acc >> SHIFT;
        if (SATURATE != 0 && res > ACC_W'({WIDTH_BIT{1'b1}})) begin
            narrow = {WIDTH_BIT{1'b1}};
        end else begin
            narrow = res[WIDTH_BIT-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        kern  <= kernel_in;
                        col   <= '0;
                        row   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        if (int'(col) == IMG_W - 1) begin
                            col <= '0;
                            row <= row + RW'(1);
                        end else begin
                            col <= col + CW'(1);
                        end
                        if (last_pix) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // Any result still pending here is the final one of the frame.
                    if (!out_valid || (out_ready && out_last)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // A new result may load in the same cycle the old one is taken.
            if (win_done) begin
                out_valid <= 1'b1;
                out_data  <= narrow;
                out_last  <= last_win;
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv2_stream.sv
// Bench for conv2_stream: three configurations (default, truncate, stride 2)
// checked against a direct window-sum model of each frame.
module tb_conv2_stream;
    import conv_pkg::*;

    localparam int N = 7;
    localparam int K = 3;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                      reset;
    logic [2:0]                start;
    logic [2:0]                pix_valid;
    logic [2:0]                pix_ready;
    logic [2:0]                out_valid;
    logic [2:0]                out_ready;
    logic [2:0]                out_last;
    logic [2:0]                busy;
    logic [2:0]                done;
    logic [K-1:0][K-1:0][7:0]  kernel;
    logic [7:0]                pix_data [3];
    logic [7:0]                out_data [3];
    state_t                    fsm_state [3];

    int                        n_cmp;
    int                        n_err;
    int                        img [N][N];
    int                        kern [K][K];
    logic [7:0]                exp_q [$];

    conv2_stream #(.IMG_W(N), .IMG_H(N), .KSIZE(K), .WIDTH_BIT(8), .STRIDE(1), .SHIFT(0), .SATURATE(1)) dut_a (
        .clock(clock), .reset(reset), .start(start[0]), .kernel_in(kernel),
        .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]), .pix_data(pix_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_last(out_last[0]), .busy(busy[0]), .done(done[0]), .fsm_state(fsm_state[0])
    );

    conv2_stream #(.IMG_W(N), .IMG_H(N), .KSIZE(K), .WIDTH_BIT(8), .STRIDE(1), .SHIFT(0), .SATURATE(0)) dut_b (
        .clock(clock), .reset(reset), .start(start[1]), .kernel_in(kernel),
        .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]), .pix_data(pix_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_last(out_last[1]), .busy(busy[1]), .done(done[1]), .fsm_state(fsm_state[1])
    );

    conv2_stream #(.IMG_W(N), .IMG_H(N), .KSIZE(K), .WIDTH_BIT(8), .STRIDE(2), .SHIFT(0), .SATURATE(1)) dut_c (
        .clock(clock), .reset(reset), .start(start[2]), .kernel_in(kernel),
        .pix_valid(pix_valid[2]), .pix_ready(pix_ready[2]), .pix_data(pix_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .out_last(out_last[2]), .busy(busy[2]), .done(done[2]), .fsm_state(fsm_state[2])
    );

    function automatic int stride_of(input int u);
        return (u == 2) ? 2 : 1;
    endfunction

    function automatic int sat_of(input int u);
        return (u == 1) ? 0 : 1;
    endfunction

    // Reference: every valid-region window summed directly from the image.
    task automatic build_expected(input int u);
        int s;
        int od;
        int acc;
        s  = stride_of(u);
        od = (N - K) / s + 1;
        exp_q.delete();
        for (int i = 0; i < od; i++) begin
            for (int j = 0; j < od; j++) begin
                acc = 0;
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        acc += kern[r][c] * img[i*s+r][j*s+c];
                    end
                end
                if (sat_of(u) != 0) exp_q.push_back((acc > 255) ? 8'd255 : 8'(acc));
                else exp_q.push_back(8'(acc % 256));
            end
        end
    endtask

    task automatic fill_image(input int mode);
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                case (mode)
                    0: img[r][c] = 1;
                    1: img[r][c] = r * 7 + c;
                    2: img[r][c] = 255;
                    default: img[r][c] = $urandom_range(255);
                endcase
            end
        end
    endtask

    task automatic fill_kernel(input int mode);
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                case (mode)
                    0: kern[r][c] = 1;
                    1: kern[r][c] = (r == 1 && c == 1) ? 1 : 0;
                    2: kern[r][c] = 255;
                    default: kern[r][c] = $urandom_range(255);
                endcase
            end
        end
    endtask

    task automatic run_frame(input int u, input int vgap, input int rgap, input int abort_at);
        int         idx;
        int         cyc;
        int         total;
        int         hs_cnt;
        int         last_hs;
        bit         fin;
        bit         held_v;
        logic [7:0] held_d;
        logic [7:0] e;
        build_expected(u);
        total   = exp_q.size();
        idx     = 0;
        cyc     = 0;
        hs_cnt  = 0;
        last_hs = -10;
        fin     = 0;
        held_v  = 0;
        held_d  = '0;
        @(negedge clock);
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) kernel[r][c] = 8'(kern[r][c]);
        start[u] = 1'b1;
        @(negedge clock);
        start[u] = 1'b0;
        kernel   = {$urandom, $urandom, $urandom};
        n_cmp++;
        if (busy[u] !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_start u=%0d got=%b want=1", u, busy[u]);
        end
        while (!fin && cyc < 4000) begin
            @(negedge clock);
            cyc++;
            if (abort_at > 0 && idx >= abort_at) begin
                pix_valid[u] = 1'b0;
                out_ready[u] = 1'b0;
                reset        = 1'b1;
                @(negedge clock);
                reset = 1'b0;
                n_cmp++;
                if (out_valid[u] !== 1'b0 || busy[u] !== 1'b0 || pix_ready[u] !== 1'b0) begin
                    n_err++;
                    $display("FAIL abort_reset u=%0d valid=%b busy=%b ready=%b want=000",
                             u, out_valid[u], busy[u], pix_ready[u]);
                end
                for (int k = 0; k < 10; k++) begin
                    @(negedge clock);
                    n_cmp++;
                    if (done[u] !== 1'b0) begin
                        n_err++;
                        $display("FAIL abort_no_done u=%0d got=%b want=0", u, done[u]);
                    end
                end
                exp_q.delete();
                return;
            end
            start[u]     = (idx < N * N) && ($urandom_range(99) < 10);
            pix_valid[u] = (idx < N * N) && ($urandom_range(99) >= vgap);
            pix_data[u]  = (idx < N * N) ? 8'(img[idx/N][idx%N]) : 8'($urandom);
            out_ready[u] = ($urandom_range(99) >= rgap);
            #1;
            if (done[u]) begin
                fin = 1;
                n_cmp++;
                if (cyc != last_hs + 1) begin
                    n_err++;
                    $display("FAIL done_timing u=%0d got_cycle=%0d want_cycle=%0d", u, cyc, last_hs + 1);
                end
            end
            if (held_v) begin
                n_cmp++;
                if (out_valid[u] !== 1'b1 || out_data[u] !== held_d) begin
                    n_err++;
                    $display("FAIL stall_hold u=%0d valid=%b data=%0d want_valid=1 data=%0d",
                             u, out_valid[u], out_data[u], held_d);
                end
            end
            if (out_valid[u] && out_ready[u]) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL extra_output u=%0d got=%0d want=none", u, out_data[u]);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data[u] !== e) begin
                        n_err++;
                        $display("FAIL out_data u=%0d idx=%0d got=%0d want=%0d", u, hs_cnt, out_data[u], e);
                    end
                end
                n_cmp++;
                if (out_last[u] !== (hs_cnt == total - 1)) begin
                    n_err++;
                    $display("FAIL out_last u=%0d idx=%0d got=%b want=%b", u, hs_cnt, out_last[u], hs_cnt == total - 1);
                end
                hs_cnt++;
                last_hs = cyc;
                held_v  = 0;
            end else begin
                held_v = out_valid[u];
                held_d = out_data[u];
            end
            if (pix_valid[u] && pix_ready[u]) idx++;
        end
        start[u]     = 1'b0;
        pix_valid[u] = 1'b0;
        out_ready[u] = 1'b0;
        n_cmp++;
        if (!fin) begin
            n_err++;
            $display("FAIL frame_timeout u=%0d pixels=%0d outputs=%0d", u, idx, hs_cnt);
        end
        n_cmp++;
        if (hs_cnt != total) begin
            n_err++;
            $display("FAIL output_count u=%0d got=%0d want=%0d", u, hs_cnt, total);
        end
        @(negedge clock);
        n_cmp++;
        if (done[u] !== 1'b0 || busy[u] !== 1'b0 || fsm_state[u] !== IDLE) begin
            n_err++;
            $display("FAIL post_frame u=%0d done=%b busy=%b state=%0d want=0,0,IDLE",
                     u, done[u], busy[u], fsm_state[u]);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        for (int u = 0; u < 3; u++) begin
            n_cmp++;
            if (pix_ready[u] !== 1'b0 || out_valid[u] !== 1'b0 || out_last[u] !== 1'b0 ||
                busy[u] !== 1'b0 || done[u] !== 1'b0 || out_data[u] !== 8'd0 || fsm_state[u] !== IDLE) begin
                n_err++;
                $display("FAIL reset_state u=%0d rdy=%b vld=%b last=%b busy=%b done=%b data=%0d want all 0",
                         u, pix_ready[u], out_valid[u], out_last[u], busy[u], done[u], out_data[u]);
            end
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_ones();
        fill_image(0);
        fill_kernel(0);
        run_frame(0, 0, 0, 0);
    endtask

    task automatic test_ramp();
        fill_image(1);
        fill_kernel(1);
        run_frame(0, 0, 0, 0);
    endtask

    task automatic test_saturate();
        fill_image(2);
        fill_kernel(2);
        run_frame(0, 0, 0, 0);
        run_frame(1, 0, 0, 0);
    endtask

    task automatic test_stride();
        fill_image(0);
        fill_kernel(0);
        run_frame(2, 0, 0, 0);
    endtask

    task automatic test_random_stalls();
        for (int f = 0; f < 6; f++) begin
            fill_image(3);
            fill_kernel(3);
            run_frame(f % 3, 30, 50, 0);
        end
        fill_image(3);
        fill_kernel(3);
        run_frame(0, 0, 50, 0);
    endtask

    task automatic test_abort();
        fill_image(3);
        fill_kernel(3);
        run_frame(0, 20, 30, 20);
        run_frame(0, 10, 20, 0);
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        reset     = 1'b1;
        start     = '0;
        pix_valid = '0;
        out_ready = '0;
        kernel    = '0;
        for (int u = 0; u < 3; u++) pix_data[u] = '0;
        test_reset();
        test_ones();
        test_ramp();
        test_saturate();
        test_stride();
        test_random_stalls();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
